// File: rtl/icache_l2_req_arbiter.sv
// icache_l2_req_arbiter
// Merges I$ line-fill misses and non-cacheable fetch requests onto the single
// L2 request channel. Only one transaction is outstanding at a time, and the
// L2 response is steered back to whichever source issued the request.
//
// Handshake: l2_req_valid_o rises in REQ and holds with a stable address until
// the cycle in which l2_req_ready_i is also high. The I$ request is taken on
// ic_req_valid_i & ic_req_ready_o. NC requests are single-cycle pulses with no
// backpressure. A pulse that cannot be served at once is parked in a
// one-entry pending slot. A later pulse overwrites that slot.
module icache_l2_req_arbiter #(
  parameter int unsigned PADDR_W     = 40,
  parameter int unsigned LINE_W      = 256,
  parameter int unsigned LINE_BYTES  = 32,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               flush_i,
  input  logic               ic_req_valid_i,
  input  logic [PADDR_W-1:0] ic_req_paddr_i,
  output logic               ic_req_ready_o,
  input  logic               nc_req_valid_i,
  input  logic [PADDR_W-1:0] nc_req_paddr_i,
  output logic               l2_req_valid_o,
  input  logic               l2_req_ready_i,
  output logic [PADDR_W-1:0] l2_req_paddr_o,
  output logic               l2_req_nc_o,
  input  logic               l2_resp_valid_i,
  input  logic [LINE_W-1:0]  l2_resp_data_i,
  output logic               ic_resp_valid_o,
  output logic [LINE_W-1:0]  ic_resp_data_o,
  output logic               nc_grant_valid_o,
  output logic [LINE_W-1:0]  nc_resp_data_o,
  output logic               err_timeout_o,
  output logic               err_proto_o,
  output logic [1:0]         dbg_state_o
);

  localparam int unsigned LINE_OFF_W = $clog2(LINE_BYTES);
  localparam int unsigned TMO_W      = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic               r_owner_nc;
  logic [PADDR_W-1:0] r_addr;
  logic               r_nc_pend;
  logic [PADDR_W-1:0] r_nc_pend_addr;
  logic               r_kill;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_err_timeout;
  logic               r_err_proto;

  logic [PADDR_W-1:0] w_nc_addr_aln;
  logic [PADDR_W-1:0] w_ic_addr_aln;
  logic               w_in_idle;
  logic               w_ic_ready;
  logic               w_take_nc;
  logic               w_take_ic;
  logic               w_ic_flush;
  logic               w_waiting;
  logic               w_waiting_nxt;
  logic               w_unused;

  // NC reads are 8-byte granules; I$ fills are whole lines.
  assign w_nc_addr_aln = {nc_req_paddr_i[PADDR_W-1:3], 3'b000};
  assign w_ic_addr_aln = {ic_req_paddr_i[PADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  assign w_unused      = ^{nc_req_paddr_i[2:0], ic_req_paddr_i[LINE_OFF_W-1:0]};

  assign w_in_idle  = (r_state == S_IDLE);
  // Gated by rstn_i so that every output reads 0 while reset is asserted.
  assign w_ic_ready = rstn_i & w_in_idle & ~nc_req_valid_i & ~r_nc_pend & ~flush_i;
  // NC wins in IDLE. A live pulse takes precedence over the parked one.
  assign w_take_nc  = w_in_idle & (nc_req_valid_i | r_nc_pend);
  assign w_take_ic  = w_in_idle & ~w_take_nc & ic_req_valid_i & w_ic_ready;
  // A flush only affects an I$-owned transaction; NC grants are always delivered.
  assign w_ic_flush = flush_i & ~r_owner_nc;

  assign w_waiting     = (r_state == S_WAIT) | (r_state == S_DRAIN);
  assign w_waiting_nxt = (w_state_nxt == S_WAIT) | (w_state_nxt == S_DRAIN);

  // State register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_take_nc || w_take_ic) w_state_nxt = S_REQ;
      // The request still completes its handshake after a flush. Its response is then dropped.
      S_REQ:   if (l2_req_ready_i) w_state_nxt = (r_kill || w_ic_flush) ? S_DRAIN : S_WAIT;
      // A response that arrives with a flush is consumed, but is not forwarded.
      S_WAIT:  if (l2_resp_valid_i) w_state_nxt = S_IDLE;
               else if (w_ic_flush) w_state_nxt = S_DRAIN;
      S_DRAIN: if (l2_resp_valid_i) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode. The response valids are combinational, in the same cycle as the L2 response.
  always_comb begin
    l2_req_valid_o   = (r_state == S_REQ);
    l2_req_paddr_o   = r_addr;
    l2_req_nc_o      = (r_state == S_REQ) & r_owner_nc;
    ic_resp_valid_o  = (r_state == S_WAIT) & ~r_owner_nc & l2_resp_valid_i & ~flush_i;
    nc_grant_valid_o = (r_state == S_WAIT) & r_owner_nc & l2_resp_valid_i;
    ic_req_ready_o   = w_ic_ready;
    dbg_state_o      = r_state;
  end

  assign ic_resp_data_o = l2_resp_data_i;
  assign nc_resp_data_o = l2_resp_data_i;
  assign err_timeout_o  = r_err_timeout;
  assign err_proto_o    = r_err_proto;

  // Source select, request address latch and the single NC pending slot.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_owner_nc     <= 1'b0;
      r_addr         <= '0;
      r_nc_pend      <= 1'b0;
      r_nc_pend_addr <= '0;
    end else if (w_take_nc) begin
      r_addr     <= nc_req_valid_i ? w_nc_addr_aln : r_nc_pend_addr;
      r_owner_nc <= 1'b1;
      r_nc_pend  <= 1'b0;
    end else if (w_take_ic) begin
      r_addr     <= w_ic_addr_aln;
      r_owner_nc <= 1'b0;
    end else if (nc_req_valid_i) begin
      r_nc_pend      <= 1'b1;
      r_nc_pend_addr <= w_nc_addr_aln;
    end
  end

  // Remember a flush that arrives while an I$ request waits for acceptance.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                     r_kill <= 1'b0;
    else if ((r_state == S_REQ) && !l2_req_ready_i)  r_kill <= r_kill | w_ic_flush;
    else                                             r_kill <= 1'b0;
  end

  // Response timeout counter: restarts on entry to WAIT/DRAIN and saturates.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)                                     r_tmo_cnt <= '0;
    else if (w_waiting_nxt && (w_state_nxt != r_state)) r_tmo_cnt <= '0;
    else if (w_waiting && (r_tmo_cnt != TMO_W'(TIMEOUT_CYC)))
                                                     r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
  end

  // Sticky debug flags. Only reset clears them.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_err_timeout <= 1'b0;
      r_err_proto   <= 1'b0;
    end else begin
      r_err_timeout <= r_err_timeout | (w_waiting && (r_tmo_cnt == TMO_W'(TIMEOUT_CYC)));
      r_err_proto   <= r_err_proto | (l2_resp_valid_i & ((r_state == S_IDLE) | (r_state == S_REQ)));
    end
  end

endmodule

// File: tb/tb_icache_l2_req_arbiter.sv
// Directed bench for icache_l2_req_arbiter. Expected L2 requests are queued when
// a source is driven, and are popped when the L2 handshake completes.
module tb_icache_l2_req_arbiter;
  localparam int PADDR_W = 40;
  localparam int LINE_W  = 256;
  localparam logic [1:0] ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT = 2'd2, ST_DRAIN = 2'd3;

  logic               clk_i, rstn_i, flush_i;
  logic               ic_req_valid_i, ic_req_ready_o;
  logic [PADDR_W-1:0] ic_req_paddr_i;
  logic               nc_req_valid_i;
  logic [PADDR_W-1:0] nc_req_paddr_i;
  logic               l2_req_valid_o, l2_req_ready_i, l2_req_nc_o;
  logic [PADDR_W-1:0] l2_req_paddr_o;
  logic               l2_resp_valid_i;
  logic [LINE_W-1:0]  l2_resp_data_i, ic_resp_data_o, nc_resp_data_o;
  logic               ic_resp_valid_o, nc_grant_valid_o, err_timeout_o, err_proto_o;
  logic [1:0]         dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;
  logic [PADDR_W:0] exp_q[$];   // {nc, paddr}
  logic [LINE_W-1:0] d;

  icache_l2_req_arbiter dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .flush_i(flush_i),
    .ic_req_valid_i(ic_req_valid_i), .ic_req_paddr_i(ic_req_paddr_i), .ic_req_ready_o(ic_req_ready_o),
    .nc_req_valid_i(nc_req_valid_i), .nc_req_paddr_i(nc_req_paddr_i),
    .l2_req_valid_o(l2_req_valid_o), .l2_req_ready_i(l2_req_ready_i),
    .l2_req_paddr_o(l2_req_paddr_o), .l2_req_nc_o(l2_req_nc_o),
    .l2_resp_valid_i(l2_resp_valid_i), .l2_resp_data_i(l2_resp_data_i),
    .ic_resp_valid_o(ic_resp_valid_o), .ic_resp_data_o(ic_resp_data_o),
    .nc_grant_valid_o(nc_grant_valid_o), .nc_resp_data_o(nc_resp_data_o),
    .err_timeout_o(err_timeout_o), .err_proto_o(err_proto_o), .dbg_state_o(dbg_state_o)
  );

  // Clock and watchdog
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=no end of test expected=end of test");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] r;
    for (int i = 0; i < LINE_W/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  // L2 side: wait for a request, stall it for 'hold' cycles, then accept it and check it against the scoreboard.
  task automatic l2_accept(input int hold);
    logic [PADDR_W:0] snap, got, exp;
    int waited;
    waited = 0;
    #1;
    while (!l2_req_valid_o && waited < 50) begin
      step(); #1;
      waited++;
    end
    if (!l2_req_valid_o) begin
      chk("req_wait_timeout", l2_req_valid_o, 1);
      return;
    end
    snap = {l2_req_nc_o, l2_req_paddr_o};
    for (int i = 0; i < hold; i++) begin
      step(); #1;
      chk("req_hold_stable", {l2_req_valid_o, l2_req_nc_o, l2_req_paddr_o}, {1'b1, snap});
    end
    l2_req_ready_i = 1'b1;
    got = {l2_req_nc_o, l2_req_paddr_o};
    n_checks++;
    assert (exp_q.size() > 0) else begin
      n_errors++;
      $error("FAIL req_unexpected: observed=%0h expected=no request", got);
    end
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      chk("req_addr_nc", got, exp);
    end
    step();
    l2_req_ready_i = 1'b0;
  endtask

  // L2 side: drive a one-beat response and check where it is steered.
  task automatic respond(input logic [LINE_W-1:0] data, input logic exp_ic, input logic exp_nc);
    l2_resp_valid_i = 1'b1;
    l2_resp_data_i  = data;
    #1;
    chk("resp_ic_valid", ic_resp_valid_o, exp_ic);
    chk("resp_nc_grant", nc_grant_valid_o, exp_nc);
    if (exp_ic) chk("resp_ic_data", ic_resp_data_o, data);
    if (exp_nc) chk("resp_nc_data", nc_resp_data_o, data);
    step();
    l2_resp_valid_i = 1'b0;
    #1;
    chk("resp_one_cycle", {ic_resp_valid_o, nc_grant_valid_o}, 2'b00);
    chk("resp_back_idle", dbg_state_o, ST_IDLE);
  endtask

  initial begin
    rstn_i = 1'b0; flush_i = 1'b0;
    ic_req_valid_i = 1'b0; ic_req_paddr_i = '0;
    nc_req_valid_i = 1'b0; nc_req_paddr_i = '0;
    l2_req_ready_i = 1'b0; l2_resp_valid_i = 1'b0; l2_resp_data_i = '0;

    // Reset state
    repeat (3) step();
    #1;
    chk("rst_l2_valid", l2_req_valid_o, 0);
    chk("rst_l2_paddr", l2_req_paddr_o, 0);
    chk("rst_l2_nc", l2_req_nc_o, 0);
    chk("rst_ic_ready", ic_req_ready_o, 0);
    chk("rst_resp_valids", {ic_resp_valid_o, nc_grant_valid_o}, 0);
    chk("rst_errs", {err_timeout_o, err_proto_o}, 0);
    chk("rst_state", dbg_state_o, ST_IDLE);
    step(); rstn_i = 1'b1; #1;
    chk("idle_ic_ready", ic_req_ready_o, 1);

    // 1: an NC pulse is issued in the next cycle, and the response is granted in the same cycle.
    step();
    nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h00_0000_0104;
    exp_q.push_back({1'b1, 40'h00_0000_0100});
    #1 chk("t1_ic_ready_blocked", ic_req_ready_o, 0);
    step(); nc_req_valid_i = 1'b0;
    #1 chk("t1_req_n_plus_1", l2_req_valid_o, 1);
    l2_accept(0);
    d = rand_line();
    respond(d, 1'b0, 1'b1);

    // 2: an I$ miss is held through 3 stall cycles, and its address is aligned to the line.
    step();
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h00_8000_1234;
    #1 chk("t2_ic_ready", ic_req_ready_o, 1);
    exp_q.push_back({1'b0, 40'h00_8000_1220});
    step(); ic_req_valid_i = 1'b0;
    #1 chk("t2_ready_low_in_req", ic_req_ready_o, 0);
    l2_accept(3);
    d = rand_line();
    respond(d, 1'b1, 1'b0);

    // 3: I$ and NC in the same cycle. NC is issued first, and the I$ request waits.
    step();
    ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h00_0000_205c;
    nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h00_0000_040f;
    exp_q.push_back({1'b1, 40'h00_0000_0408});
    #1 chk("t3_ic_ready_lost", ic_req_ready_o, 0);
    step(); nc_req_valid_i = 1'b0;
    l2_accept(0);
    d = rand_line();
    respond(d, 1'b0, 1'b1);
    chk("t3_ic_ready_after", ic_req_ready_o, 1);
    exp_q.push_back({1'b0, 40'h00_0000_2040});
    step(); ic_req_valid_i = 1'b0;
    l2_accept(1);
    d = rand_line();
    respond(d, 1'b1, 1'b0);

    // 4a: a flush during an I$ WAIT moves to DRAIN, and the response is dropped.
    step(); ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h00_0000_3000;
    exp_q.push_back({1'b0, 40'h00_0000_3000});
    step(); ic_req_valid_i = 1'b0;
    l2_accept(0);
    flush_i = 1'b1;
    step(); flush_i = 1'b0;
    #1 chk("t4a_drain", dbg_state_o, ST_DRAIN);
    d = rand_line();
    respond(d, 1'b0, 1'b0);

    // 4b: a flush during an I$ REQ still completes the handshake, then drains.
    step(); ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h00_0000_3100;
    exp_q.push_back({1'b0, 40'h00_0000_3100});
    step(); ic_req_valid_i = 1'b0; flush_i = 1'b1;
    #1 chk("t4b_in_req", dbg_state_o, ST_REQ);
    step(); flush_i = 1'b0;
    l2_accept(0);
    #1 chk("t4b_drain", dbg_state_o, ST_DRAIN);
    d = rand_line();
    respond(d, 1'b0, 1'b0);

    // 4c: a flush during an NC WAIT has no effect.
    step(); nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h00_0000_0500;
    exp_q.push_back({1'b1, 40'h00_0000_0500});
    step(); nc_req_valid_i = 1'b0;
    l2_accept(0);
    flush_i = 1'b1;
    step(); flush_i = 1'b0;
    #1 chk("t4c_still_wait", dbg_state_o, ST_WAIT);
    d = rand_line();
    respond(d, 1'b0, 1'b1);

    // 5: two NC pulses arrive during an I$ WAIT. The latest one is issued, at M+2.
    step(); ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h00_0000_4000;
    exp_q.push_back({1'b0, 40'h00_0000_4000});
    step(); ic_req_valid_i = 1'b0;
    l2_accept(0);
    nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h00_0000_0200;
    step(); nc_req_valid_i = 1'b0;
    step(); nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h00_0000_0300;
    step(); nc_req_valid_i = 1'b0;
    exp_q.push_back({1'b1, 40'h00_0000_0300});
    #1 chk("t5_no_req_in_wait", l2_req_valid_o, 0);
    d = rand_line();
    respond(d, 1'b1, 1'b0);
    chk("t5_no_req_m1", l2_req_valid_o, 0);
    chk("t5_ic_ready_pend", ic_req_ready_o, 0);
    step(); #1 chk("t5_req_m2", l2_req_valid_o, 1);
    l2_accept(0);
    d = rand_line();
    respond(d, 1'b0, 1'b1);
    step(); #1 chk("t5_single_nc", l2_req_valid_o, 0);

    // 6: the timeout flag is sticky. A response in IDLE is a protocol error.
    chk("t6_errs_clear", {err_timeout_o, err_proto_o}, 0);
    step(); nc_req_valid_i = 1'b1; nc_req_paddr_i = 40'h00_0000_0010;
    exp_q.push_back({1'b1, 40'h00_0000_0010});
    step(); nc_req_valid_i = 1'b0;
    l2_accept(0);
    repeat (1000) step();
    #1 chk("t6_tmo_not_yet", err_timeout_o, 0);
    repeat (100) step();
    #1 chk("t6_tmo_set", err_timeout_o, 1);
    chk("t6_keeps_waiting", dbg_state_o, ST_WAIT);
    d = rand_line();
    respond(d, 1'b0, 1'b1);
    chk("t6_tmo_sticky", err_timeout_o, 1);
    chk("t6_proto_clear", err_proto_o, 0);
    step(); l2_resp_valid_i = 1'b1;
    #1 chk("t6_idle_resp_dropped", {ic_resp_valid_o, nc_grant_valid_o}, 0);
    step(); l2_resp_valid_i = 1'b0;
    #1 chk("t6_proto_set", err_proto_o, 1);
    step(); #1 chk("t6_proto_sticky", err_proto_o, 1);

    // 7: a reset in mid-transaction clears everything. A late response is a protocol error.
    step(); ic_req_valid_i = 1'b1; ic_req_paddr_i = 40'h00_0000_5000;
    exp_q.push_back({1'b0, 40'h00_0000_5000});
    step(); ic_req_valid_i = 1'b0;
    l2_accept(0);
    rstn_i = 1'b0;
    #1;
    chk("t7_rst_state", dbg_state_o, ST_IDLE);
    chk("t7_rst_errs", {err_timeout_o, err_proto_o}, 0);
    chk("t7_rst_l2_valid", l2_req_valid_o, 0);
    step(); rstn_i = 1'b1;
    step(); l2_resp_valid_i = 1'b1;
    #1 chk("t7_late_resp_dropped", ic_resp_valid_o, 0);
    step(); l2_resp_valid_i = 1'b0;
    #1 chk("t7_late_resp_proto", err_proto_o, 1);
    chk("t7_state_idle", dbg_state_o, ST_IDLE);

    chk("sb_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
